// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: sequencer states and default widths.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fetch_state_t;

  localparam int INSTR_W = 40;
  localparam int PC_W    = 5;
endpackage

// File: rtl/instruction_fetch.sv
// PC sequencer + instruction register between ROM and decoder; instr valid 1 cycle after pc is driven.
// Decoder backpressure (instr_valid && !instr_ready) holds instr, instr_pc and pc.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = INSTR_W,
  parameter int PC_WIDTH          = PC_W,
  parameter int LAST_ADDR         = 29,
  parameter bit WRAP_EN           = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          jump_target,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic                         done
);

  fetch_state_t        state;
  logic                load;
  logic                capture;
  logic                at_last;
  logic                go;
  logic                drain_done;
  logic                discard;
  logic [PC_WIDTH-1:0] pc_inc;

  assign load       = !instr_valid || instr_ready;
  assign capture    = (state == RUN) && !halt && !jump && load;
  assign at_last    = (pc == PC_WIDTH'(LAST_ADDR));
  assign pc_inc     = at_last ? '0 : pc + 1'b1;
  assign go         = start && !halt && ((state == IDLE) || (state == HALTED));
  assign drain_done = (state == DRAIN) && !halt && instr_valid && instr_ready;
  // halt drops any pending word; jump flushes it so the old path is never presented
  assign discard    = (((state == RUN) || (state == DRAIN)) && halt) ||
                      ((state == RUN) && jump) || drain_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (go) begin
            state <= RUN;
            pc    <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state <= HALTED;
            done  <= 1'b1;
          end else if (jump) begin
            pc <= jump_target;
          end else if (load) begin
            pc <= pc_inc;
            if (!WRAP_EN && at_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (halt || drain_done) begin
            state <= HALTED;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr       <= instruction;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (discard) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: one wrapping and one stopping instance share stimulus, checked against a behavioural model.
module tb_instruction_fetch;
  localparam int LAST = 29;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst, start, halt, jump, instr_ready;
  logic [4:0]  jump_target;
  logic [4:0]  pc0, ipc0, pc1, ipc1;
  logic [39:0] ins0, ins1, instr0, instr1;
  logic        v0, v1, d0, d1;

  int checks = 0;
  int fails  = 0;

  int          m_mode  [2];
  logic [4:0]  m_pc    [2];
  logic [4:0]  m_ipc   [2];
  logic [39:0] m_instr [2];
  logic        m_valid [2];

  always #5 clk = ~clk;

  function automatic logic [39:0] rom(input logic [4:0] a);
    return 40'h100 + {35'd0, a};
  endfunction

  assign ins0 = rom(pc0);
  assign ins1 = rom(pc1);

  instruction_fetch #(.INSTRUCTION_WIDTH(40), .PC_WIDTH(5), .LAST_ADDR(LAST), .WRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jump(jump), .jump_target(jump_target),
    .pc(pc0), .instruction(ins0), .instr(instr0), .instr_pc(ipc0), .instr_valid(v0),
    .instr_ready(instr_ready), .done(d0));

  instruction_fetch #(.INSTRUCTION_WIDTH(40), .PC_WIDTH(5), .LAST_ADDR(LAST), .WRAP_EN(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jump(jump), .jump_target(jump_target),
    .pc(pc1), .instruction(ins1), .instr(instr1), .instr_pc(ipc1), .instr_valid(v1),
    .instr_ready(instr_ready), .done(d1));

  function automatic logic [51:0] obs_vec(input int l);
    if (l == 0) return {pc0, ipc0, v0, d0, instr0};
    return {pc1, ipc1, v1, d1, instr1};
  endfunction

  function automatic logic [51:0] exp_vec(input int l);
    return {m_pc[l], m_ipc[l], m_valid[l], (m_mode[l] == M_HALT), m_instr[l]};
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_mode[l] = M_IDLE; m_pc[l] = '0; m_ipc[l] = '0; m_instr[l] = '0; m_valid[l] = 1'b0;
    end
  endtask

  // One clock edge of the program-counter rules, lane 0 wraps, lane 1 stops after LAST.
  task automatic model_step();
    for (int l = 0; l < 2; l++) begin
      case (m_mode[l])
        M_IDLE, M_HALT: if (start && !halt) begin m_mode[l] = M_RUN; m_pc[l] = '0; end
        M_RUN: begin
          if (halt) begin
            m_mode[l] = M_HALT; m_valid[l] = 1'b0;
          end else if (jump) begin
            m_pc[l] = jump_target; m_valid[l] = 1'b0;
          end else if (!m_valid[l] || instr_ready) begin
            m_instr[l] = rom(m_pc[l]); m_ipc[l] = m_pc[l]; m_valid[l] = 1'b1;
            if (l == 1 && int'(m_pc[l]) == LAST) m_mode[l] = M_DRAIN;
            m_pc[l] = (int'(m_pc[l]) == LAST) ? 5'd0 : 5'((int'(m_pc[l]) + 1) % 32);
          end
        end
        default: begin
          if (halt) begin
            m_mode[l] = M_HALT; m_valid[l] = 1'b0;
          end else if (m_valid[l] && instr_ready) begin
            m_mode[l] = M_HALT; m_valid[l] = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt = 1'b0; jump = 1'b0; instr_ready = 1'b1; jump_target = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_pc0(input logic [4:0] target, input int budget, input string name);
    int n = 0;
    while (pc0 !== target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (pc0 !== target) begin
      fails++;
      $display("FAIL %s timeout pc=%0d required %0d", name, pc0, target);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #2;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (obs_vec(l) !== 52'd0) begin
        fails++; $display("FAIL reset_state lane%0d got %h required 0", l, obs_vec(l));
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (obs_vec(l) !== exp_vec(l)) begin
          fails++; $display("FAIL idle_no_fetch lane%0d got %h required %h", l, obs_vec(l), exp_vec(l));
        end
      end
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    pulse_start();
    checks++;
    if (pc0 !== 5'd0 || v0 !== 1'b0) begin
      fails++; $display("FAIL seq_start pc=%0d valid=%b required 0/0", pc0, v0);
    end
    for (int k = 0; k < 34; k++) begin
      tick();
      checks++;
      if (v0 !== 1'b1 || ipc0 !== 5'(k % 30) || instr0 !== rom(5'(k % 30))) begin
        fails++; $display("FAIL seq_order k=%0d got ipc=%0d instr=%h valid=%b required ipc=%0d", k, ipc0, instr0, v0, k % 30);
      end
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (obs_vec(l) !== exp_vec(l)) begin
          fails++; $display("FAIL seq_model lane%0d got %h required %h", l, obs_vec(l), exp_vec(l));
        end
      end
    end
    checks++;
    if (d1 !== 1'b1 || v1 !== 1'b0 || pc1 !== 5'd0) begin
      fails++; $display("FAIL stop_halted done=%b valid=%b pc=%0d required 1/0/0", d1, v1, pc1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (d1 !== 1'b0 || v1 !== 1'b0) begin
      fails++; $display("FAIL restart_edge done=%b valid=%b required 0/0", d1, v1);
    end
    tick();
    checks++;
    if (v1 !== 1'b1 || ipc1 !== 5'd0 || instr1 !== 40'h100) begin
      fails++; $display("FAIL restart_fetch valid=%b ipc=%0d instr=%h required 1/0/100", v1, ipc1, instr1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    pulse_start();
    run_until_pc0(5'd5, 20, "bp_wait");
    instr_ready = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (ipc0 !== 5'd4 || pc0 !== 5'd5 || instr0 !== 40'h104 || v0 !== 1'b1) begin
        fails++; $display("FAIL bp_hold ipc=%0d pc=%0d instr=%h valid=%b required 4/5/104/1", ipc0, pc0, instr0, v0);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (ipc0 !== 5'd5 || instr0 !== 40'h105) begin
      fails++; $display("FAIL bp_release ipc=%0d instr=%h required 5/105", ipc0, instr0);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    pulse_start();
    run_until_pc0(5'd7, 20, "jump_wait");
    jump = 1'b1; jump_target = 5'd20;
    tick();
    jump = 1'b0;
    checks++;
    if (v0 !== 1'b0 || pc0 !== 5'd20) begin
      fails++; $display("FAIL jump_flush valid=%b pc=%0d required 0/20", v0, pc0);
    end
    tick();
    checks++;
    if (v0 !== 1'b1 || ipc0 !== 5'd20 || instr0 !== 40'h114) begin
      fails++; $display("FAIL jump_target valid=%b ipc=%0d instr=%h required 1/20/114", v0, ipc0, instr0);
    end
  endtask

  task automatic test_halt_jump();
    apply_reset();
    pulse_start();
    run_until_pc0(5'd10, 20, "halt_wait");
    halt = 1'b1; jump = 1'b1; jump_target = 5'd3;
    tick();
    checks++;
    if (d0 !== 1'b1 || v0 !== 1'b0 || pc0 !== 5'd10) begin
      fails++; $display("FAIL halt_jump done=%b valid=%b pc=%0d required 1/0/10", d0, v0, pc0);
    end
    jump = 1'b0; start = 1'b1;
    tick();
    checks++;
    if (d0 !== 1'b1 || pc0 !== 5'd10) begin
      fails++; $display("FAIL halt_beats_start done=%b pc=%0d required 1/10", d0, pc0);
    end
    halt = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (d0 !== 1'b0 || pc0 !== 5'd0 || v0 !== 1'b0) begin
      fails++; $display("FAIL halt_restart done=%b pc=%0d valid=%b required 0/0/0", d0, pc0, v0);
    end
    tick();
    checks++;
    if (v0 !== 1'b1 || ipc0 !== 5'd0) begin
      fails++; $display("FAIL halt_refetch valid=%b ipc=%0d required 1/0", v0, ipc0);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    pulse_start();
    run_until_pc0(5'd12, 20, "arst_wait");
    #3 rst = 1'b1;
    model_reset();
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (obs_vec(l) !== 52'd0) begin
        fails++; $display("FAIL async_reset lane%0d got %h required 0", l, obs_vec(l));
      end
    end
    #2 rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (v0 !== 1'b0 || pc0 !== 5'd0 || d0 !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle valid=%b pc=%0d done=%b required 0/0/0", v0, pc0, d0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    pulse_start();
    for (int n = 0; n < 600; n++) begin
      start       = ($urandom_range(0, 99) < 6);
      halt        = ($urandom_range(0, 99) < 3);
      jump        = ($urandom_range(0, 99) < 10);
      instr_ready = ($urandom_range(0, 99) < 75);
      jump_target = 5'($urandom_range(0, 31));
      tick();
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (obs_vec(l) !== exp_vec(l)) begin
          fails++; $display("FAIL random n=%0d lane%0d got %h required %h", n, l, obs_vec(l), exp_vec(l));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_halt_jump();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Program-counter sequencer and instruction register sitting between the instruction ROM and the decoder. Drives the ROM address (`pc`) and samples the 40-bit instruction the ROM returns combinationally in the same cycle. Presents instructions to the decoder over a valid/ready handshake. Handles jumps (with flush), external halt, restart, and end-of-program wrap or stop.

Parameters:
INSTRUCTION_WIDTH, 40, width of one instruction word
PC_WIDTH, 5, ROM address width
LAST_ADDR, 29, last valid program address
WRAP_EN, 1, 1: pc wraps LAST_ADDR->0; 0: stop after LAST_ADDR

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begin or restart execution at address 0
halt  input  1  level; stop fetching
jump  input  1  redirect request, sampled in RUN only
jump_target  input  PC_WIDTH  redirect address
pc  output  PC_WIDTH  ROM address; equals pc register, no combinational path from inputs
instruction  input  INSTRUCTION_WIDTH  ROM read data for the current pc
instr  output  INSTRUCTION_WIDTH  registered instruction to decoder
instr_pc  output  PC_WIDTH  address `instr` was fetched from
instr_valid  output  1  `instr` holds an unconsumed instruction
instr_ready  input  1  decoder accepts `instr` this cycle
done  output  1  high in HALTED

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE; pc=0; instr=0; instr_pc=0; instr_valid=0; done=0.
- Load condition: `load = !instr_valid || instr_ready`.
- Capture on a load edge:
  - instr <= instruction; instr_pc <= pc; instr_valid <= 1.
  - pc <= (pc==LAST_ADDR) ? 0 : pc+1, modulo 2^PC_WIDTH.
- Latency: instruction at pc is visible on `instr` 1 cycle after pc is driven.
- States:
  - IDLE: no capture; pc held. `start` -> RUN, pc<=0.
  - RUN: captures on every load edge. If no stall, throughput is one instruction per cycle.
    - Stall: instr_valid && !instr_ready. Then instr, instr_pc and pc are all held unchanged.
  - DRAIN: entered only when WRAP_EN=0, on the capture of pc==LAST_ADDR. No further captures. When instr_ready && instr_valid: instr_valid<=0 -> HALTED.
  - HALTED: done=1; pc held; instr_valid=0. `start` -> RUN, pc<=0, done<=0.
- Priority in RUN/DRAIN, highest first:
  1. halt: -> HALTED next edge, instr_valid<=0 (pending instruction discarded), pc held.
  2. jump (RUN only):
     - pc<=jump_target; instr_valid<=0 (flush); no capture this edge.
     - Target instruction is valid 2 edges after the jump cycle.
     - jump in DRAIN is ignored.
  3. Normal load/stall.
- `start` in RUN or DRAIN is ignored.
- `start` and `halt` together in IDLE/HALTED: halt wins; no transition from IDLE. HALTED stays.
- jump_target > LAST_ADDR is legal: fetched as-is, then sequential increment continues up to LAST_ADDR rule or natural 2^PC_WIDTH wrap.
- Handshake rule: instr, instr_pc stable while instr_valid && !instr_ready.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, RUN, DRAIN, HALTED}.
  - default widths INSTR_W=40, PC_W=5.
- No sub-module. pc next-state and the instruction register are each a single always_ff. This block plus the existing ROM form the fetch stage.

Test Plan:
- Sequential fetch with WRAP_EN=1, instr_ready=1, ROM word[k]=k+0x100: after reset, pulse start -> instr_pc 0,1,…,29,0,1 on consecutive cycles, instr=0x100+instr_pc, instr_valid continuous.
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=4 -> instr, instr_pc=4 and pc=5 held 3 cycles; instr_pc 5 follows on the first cycle after ready returns.
- Jump at pc=7 to 20 -> next cycle instr_valid=0, pc=20; following cycle instr_pc=20. Instruction 7 is never presented.
- WRAP_EN=0: after instr_pc=29 is accepted -> instr_valid=0, done=1, pc stays; start -> instr_pc 0 two edges later, done=0.
- halt and jump in the same cycle at pc=10 -> HALTED, pc=10, instr_valid=0, done=1; jump has no effect.
- Async reset asserted between clock edges mid-RUN -> all outputs 0 and state IDLE before the next edge; no fetch until start.
